// File: rtl/softmax_pkg.sv
// softmax_pkg
// Shared definitions for the softmax exp sequencer: FSM state encoding,
// Q-format constants for scores (Q16.16) and exp results (Q1.15), and the
// saturating subtract that forms the exp operand (score - row max).
package softmax_pkg;

  localparam int SCORE_WIDTH     = 33;
  localparam int SCORE_FRAC_BITS = 16;
  localparam int EXP_FRAC_BITS   = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAX,
    ST_RD,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } state_e;

  // a - b evaluated one bit wider, then clamped back into SCORE_WIDTH.
  // Overflow shows up as the top two bits of the wide result disagreeing.
  function automatic logic [SCORE_WIDTH-1:0] sat_sub(
    input logic [SCORE_WIDTH-1:0] a,
    input logic [SCORE_WIDTH-1:0] b
  );
    logic signed [SCORE_WIDTH:0] diff;
    logic [SCORE_WIDTH-1:0]      res;
    diff = $signed({a[SCORE_WIDTH-1], a}) - $signed({b[SCORE_WIDTH-1], b});
    if (diff[SCORE_WIDTH] != diff[SCORE_WIDTH-1]) begin
      res = diff[SCORE_WIDTH] ? {1'b1, {(SCORE_WIDTH-1){1'b0}}}
                              : {1'b0, {(SCORE_WIDTH-1){1'b1}}};
    end else begin
      res = diff[SCORE_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/softmax_exp_sequencer.sv
// softmax_exp_sequencer
// Runs one softmax row through the shared exp unit: max-scan over the score
// buffer, then one (score - max) operand per element to the exp unit, each
// result written to the probability buffer and summed for the normaliser.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, row_len        row request and element count (clamped to VEC_LEN)
//   busy, done, err       status; err (exp unit timeout) is valid with done
//   rd_en, rd_addr,       score buffer read port, data returns 1 cycle later
//   rd_data
//   start_exp, x_in       exp unit request pulse and held operand
//   y_out, exp_done       exp unit result and result-valid level
//   wr_en, wr_addr,       probability buffer write port
//   wr_data
//   sum_out               sum of exp results over the row, valid from done
//
// IN_WIDTH must equal softmax_pkg::SCORE_WIDTH (the subtract is built there).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start (ignored during the done cycle)
// ST_MAX    | streaming reads 0..len-1, tracking the signed maximum
// ST_RD     | read of element i in flight
// ST_ISSUE  | form saturated (score - max), pulse start_exp
// ST_WAIT   | waiting for exp_done, timeout down-counter running
// ST_FINISH | publish sum, pulse done, drop busy
module softmax_exp_sequencer
  import softmax_pkg::*;
#(
  parameter int VEC_LEN    = 64,
  parameter int ADDR_WIDTH = $clog2(VEC_LEN),
  parameter int IN_WIDTH   = SCORE_WIDTH,
  parameter int EXP_WIDTH  = 16,
  parameter int SUM_WIDTH  = EXP_WIDTH + ADDR_WIDTH + 1,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   row_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [IN_WIDTH-1:0]   rd_data,
  output logic                  start_exp,
  output logic [IN_WIDTH-1:0]   x_in,
  input  logic [EXP_WIDTH-1:0]  y_out,
  input  logic                  exp_done,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [EXP_WIDTH-1:0]  wr_data,
  output logic [SUM_WIDTH-1:0]  sum_out
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] VEC_LEN_C = CNT_W'(VEC_LEN);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [IN_WIDTH-1:0]   max_q, max_d;
  logic [SUM_WIDTH-1:0]  sum_q, sum_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  start_exp_q, start_exp_d;
  logic [IN_WIDTH-1:0]   x_in_q, x_in_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [EXP_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [SUM_WIDTH-1:0]  sum_out_q, sum_out_d;

  logic [CNT_W-1:0]      cnt_nxt;
  logic                  last_elem;
  logic                  exp_valid;

  assign cnt_nxt   = cnt_q + CNT_W'(1);
  assign last_elem = ({1'b0, idx_q} == (len_q - CNT_W'(1)));
  // While start_exp is still high the exp unit has not yet seen the request,
  // so exp_done may be the previous element's level; ignore it that cycle.
  assign exp_valid = exp_done && !start_exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      sum_q       <= '0;
      tmr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      start_exp_q <= 1'b0;
      x_in_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      sum_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      max_q       <= max_d;
      sum_q       <= sum_d;
      tmr_q       <= tmr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      start_exp_q <= start_exp_d;
      x_in_q      <= x_in_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      sum_out_q   <= sum_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    max_d       = max_q;
    sum_d       = sum_q;
    tmr_d       = tmr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    start_exp_d = 1'b0;
    x_in_d      = x_in_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    sum_out_d   = sum_out_q;

    unique case (state_q)
      ST_IDLE: begin
        // done_q marks the completion cycle; a start there is dropped.
        if (start && !done_q) begin
          len_d  = (row_len > VEC_LEN_C) ? VEC_LEN_C : row_len;
          sum_d  = '0;
          err_d  = 1'b0;
          busy_d = 1'b1;
          cnt_d  = '0;
          if (row_len == '0) begin
            state_d = ST_FINISH;
          end else begin
            state_d   = ST_MAX;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
          end
        end
      end

      // cnt_q counts MAX cycles; data for address cnt_q-1 is on rd_data.
      ST_MAX: begin
        cnt_d = cnt_nxt;
        if (cnt_nxt < len_q) begin
          rd_en_d   = 1'b1;
          rd_addr_d = cnt_nxt[ADDR_WIDTH-1:0];
        end
        if (cnt_q == CNT_W'(1)) begin
          max_d = rd_data;
        end else if (cnt_q != '0 && $signed(rd_data) > $signed(max_q)) begin
          max_d = rd_data;
        end
        if (cnt_q == len_q) begin
          state_d   = ST_RD;
          idx_d     = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end

      ST_RD: begin
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        x_in_d      = sat_sub(rd_data, max_q);
        start_exp_d = 1'b1;
        tmr_d       = TMR_LOAD;
        state_d     = ST_WAIT;
      end

      ST_WAIT: begin
        if (exp_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = y_out;
          sum_d     = sum_q + {{(SUM_WIDTH-EXP_WIDTH){1'b0}}, y_out};
          if (last_elem) begin
            state_d = ST_FINISH;
          end else begin
            idx_d     = idx_q + ADDR_WIDTH'(1);
            rd_en_d   = 1'b1;
            rd_addr_d = idx_q + ADDR_WIDTH'(1);
            state_d   = ST_RD;
          end
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      ST_FINISH: begin
        done_d    = 1'b1;
        sum_out_d = sum_q;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign start_exp = start_exp_q;
  assign x_in      = x_in_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign sum_out   = sum_out_q;

endmodule
